// File: rtl/serial_cmp_feeder_if.sv
// Host/comparator bundle for serial_cmp_feeder: operand handshake, result,
// and the serial lines plus reset driven into the magnitude comparator.
interface serial_cmp_feeder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             g_in;
  logic             e_in;
  logic             l_in;
  logic             x_out;
  logic             y_out;
  logic             cmp_reset;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  // Environment side: issues requests and plays the comparator.
  modport master (
    output start, a, b, g_in, e_in, l_in,
    input  x_out, y_out, cmp_reset, busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b, g_in, e_in, l_in,
    output x_out, y_out, cmp_reset, busy, done, gt, eq, lt
  );
endinterface

// File: rtl/serial_cmp_feeder.sv
// Bit-serial feeder for the serial magnitude comparator: clears it, streams A/B MSB-first,
// then latches g/e/l. Define SERIAL_CMP_EARLY_EXIT_EN to stop shifting once e_in drops.
module serial_cmp_feeder #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_cmp_feeder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CW-1:0]    cnt_q;
  logic             x_q;
  logic             y_q;
  logic             clr_q;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic             shift_end_d;

  // Decide whether the current SHIFT edge is the last one.
  always_comb begin
    shift_end_d = (cnt_q == CNT_LAST);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (!bus.e_in) begin
      shift_end_d = 1'b1;
    end else begin
      shift_end_d = (cnt_q == CNT_LAST);
    end
`else
    shift_end_d = (cnt_q == CNT_LAST);
`endif
  end

  // Control FSM; x/y are registered one bit ahead so the MSB is on the line in the first SHIFT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          x_q <= 1'b0;
          y_q <= 1'b0;
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            cnt_q   <= {CW{1'b0}};
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_CLR;
          end else begin
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CLR: begin
          clr_q   <= 1'b0;
          x_q     <= sa_q[WIDTH-1];
          y_q     <= sb_q[WIDTH-1];
          sa_q    <= {sa_q[WIDTH-2:0], 1'b0};
          sb_q    <= {sb_q[WIDTH-2:0], 1'b0};
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (shift_end_d) begin
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            state_q <= S_DONE;
          end else begin
            x_q     <= sa_q[WIDTH-1];
            y_q     <= sb_q[WIDTH-1];
            sa_q    <= {sa_q[WIDTH-2:0], 1'b0};
            sb_q    <= {sb_q[WIDTH-2:0], 1'b0};
            state_q <= S_SHIFT;
          end
        end
        S_DONE: begin
          x_q     <= 1'b0;
          y_q     <= 1'b0;
          gt_q    <= bus.g_in;
          eq_q    <= bus.e_in;
          lt_q    <= bus.l_in;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          x_q     <= 1'b0;
          y_q     <= 1'b0;
          clr_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Comparator reset tracks block reset directly so it is held for the whole reset interval.
  assign bus.cmp_reset = reset | clr_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;

endmodule
